// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, IDLE/RUNNING/CLEAR sequencing,
// and an MM:SS BCD elapsed-time counter driven by an internal prescaler.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100,
  parameter int PW       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_lvl,
  input  logic       stop_lvl,
  input  logic       clear_lvl,
  output logic [1:0] state,
  output logic       running,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    CLEAR   = 2'b10
  } state_t;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  state_t        state_r, state_s;
  logic          running_r;
  logic          start_prev_r, stop_prev_r, clear_prev_r;
  logic          edge_start_s, edge_stop_s, edge_clear_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [3:0]    so_r, st_r, mo_r, mt_r;
  logic [3:0]    so_s, st_s, mo_s, mt_s;
  logic          wrap_r, wrap_s;
  logic          adv_s, tick_s;

  assign edge_start_s = start_lvl & ~start_prev_r;
  assign edge_stop_s  = stop_lvl  & ~stop_prev_r;
  assign edge_clear_s = clear_lvl & ~clear_prev_r;

  // A stop or clear edge freezes the prescaler and swallows a coincident tick.
  assign adv_s  = (state_r == RUNNING) && !edge_stop_s && !edge_clear_s;
  assign tick_s = (state_r == RUNNING) && (presc_r == PRE_MAX);

  // Next-state decode with clear > stop > start priority.
  always_comb begin
    state_s = state_r;
    if (edge_clear_s) begin
      state_s = CLEAR;
    end else begin
      case (state_r)
        IDLE:    state_s = edge_start_s ? RUNNING : IDLE;
        RUNNING: state_s = edge_stop_s ? IDLE : RUNNING;
        CLEAR:   state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Prescaler and cascaded BCD digit update.
  always_comb begin
    presc_s = presc_r;
    so_s    = so_r;
    st_s    = st_r;
    mo_s    = mo_r;
    mt_s    = mt_r;
    wrap_s  = 1'b0;
    if (edge_clear_s || (state_r == CLEAR)) begin
      presc_s = {PW{1'b0}};
      so_s    = 4'd0;
      st_s    = 4'd0;
      mo_s    = 4'd0;
      mt_s    = 4'd0;
    end else if (adv_s && tick_s) begin
      presc_s = {PW{1'b0}};
      if (so_r != 4'd9) begin
        so_s = so_r + 4'd1;
      end else begin
        so_s = 4'd0;
        if (st_r != 4'd5) begin
          st_s = st_r + 4'd1;
        end else begin
          st_s = 4'd0;
          if (mo_r != 4'd9) begin
            mo_s = mo_r + 4'd1;
          end else begin
            mo_s = 4'd0;
            if (mt_r != 4'd9) begin
              mt_s = mt_r + 4'd1;
            end else begin
              mt_s   = 4'd0;
              wrap_s = 1'b1;
            end
          end
        end
      end
    end else if (adv_s) begin
      presc_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      presc_s = presc_r;
    end
  end

  // State, edge history, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      running_r    <= 1'b0;
      start_prev_r <= 1'b1;
      stop_prev_r  <= 1'b1;
      clear_prev_r <= 1'b1;
      presc_r      <= {PW{1'b0}};
      so_r         <= 4'd0;
      st_r         <= 4'd0;
      mo_r         <= 4'd0;
      mt_r         <= 4'd0;
      wrap_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      running_r    <= (state_s == RUNNING);
      start_prev_r <= start_lvl;
      stop_prev_r  <= stop_lvl;
      clear_prev_r <= clear_lvl;
      presc_r      <= presc_s;
      so_r         <= so_s;
      st_r         <= st_s;
      mo_r         <= mo_s;
      mt_r         <= mt_s;
      wrap_r       <= wrap_s;
    end
  end

  assign state    = state_r;
  assign running  = running_r;
  assign sec_ones = so_r;
  assign sec_tens = st_r;
  assign min_ones = mo_r;
  assign min_tens = mt_r;
  assign wrap     = wrap_r;

endmodule
